// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. It grants one requester, latches its byte and pulses the
// transmitter start. It then waits for the done edge or a watchdog timeout,
// and finally holds an inter-frame gap before it arbitrates again.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data_byte,
  input  logic                          i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          ptr, ptr_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [GW-1:0]          gap_cnt, gap_nxt;
  logic                   done_q;
  logic                   done_edge;
  logic                   found;
  logic [IW-1:0]          winner;
  logic [DATA_WIDTH-1:0]  sel_byte;
  logic [NUM_REQ-1:0]     ready_nxt;
  logic                   start_nxt;
  logic                   timeout_nxt;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic [IW-1:0]          grant_nxt;

  // A done level left high from the previous frame only counts once it has dropped and risen again.
  assign done_edge = i_tx_done & ~done_q;

  // Round-robin search: the first valid requester at or after ptr (with wrap-around) wins.
  always_comb begin
    logic [IW-1:0] cand;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winning requester's byte from the packed data bus.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IW'(k)) sel_byte = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and next-output decode; the outputs themselves are registered below.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    timer_nxt   = timer;
    gap_nxt     = gap_cnt;
    ready_nxt   = '0;
    start_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    data_nxt    = o_tx_data_byte;
    grant_nxt   = o_grant_id;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = START;
          ready_nxt = NUM_REQ'(1) << winner;
          start_nxt = 1'b1;
          data_nxt  = sel_byte;
          grant_nxt = winner;
          ptr_nxt   = (winner == LAST_REQ) ? '0 : winner + IW'(1);
        end
      end
      START: begin
        state_nxt = WAIT;
        timer_nxt = '0;
      end
      WAIT: begin
        timer_nxt = timer + TW'(1);
        if (done_edge || timer == TIMER_LAST) begin
          timeout_nxt = ~done_edge;
          gap_nxt     = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else gap_nxt = gap_cnt + GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, done history and registered outputs; reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      timer          <= '0;
      gap_cnt        <= '0;
      done_q         <= 1'b0;
      o_req_ready    <= '0;
      o_tx_start     <= 1'b0;
      o_tx_data_byte <= '0;
      o_grant_id     <= '0;
      o_busy         <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      timer          <= timer_nxt;
      gap_cnt        <= gap_nxt;
      done_q         <= i_tx_done;
      o_req_ready    <= ready_nxt;
      o_tx_start     <= start_nxt;
      o_tx_data_byte <= data_nxt;
      o_grant_id     <= grant_nxt;
      o_busy         <= (state_nxt != IDLE);
      o_timeout      <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A (gap 4, timeout 50) and
// instance B (no gap) driven from one linear stimulus sequence.
module tb_uart_tx_arbiter;

  localparam int GAP_A = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  valid_a, ready_a, valid_b, ready_b;
  logic [31:0] data_a, data_b;
  logic [7:0]  byte_a, byte_b;
  logic [1:0]  grant_a, grant_b;
  logic        done_a, start_a, busy_a, tmo_a;
  logic        done_b, start_b, busy_b, tmo_b;

  int vectors;
  int miscompares;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(GAP_A), .TIMEOUT(50)) dut_a (
    .clk(clk), .reset(reset), .i_req_valid(valid_a), .i_req_data(data_a),
    .o_req_ready(ready_a), .o_tx_start(start_a), .o_tx_data_byte(byte_a),
    .i_tx_done(done_a), .o_grant_id(grant_a), .o_busy(busy_a), .o_timeout(tmo_a));

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT(50)) dut_b (
    .clk(clk), .reset(reset), .i_req_valid(valid_b), .i_req_data(data_b),
    .o_req_ready(ready_b), .o_tx_start(start_b), .o_tx_data_byte(byte_b),
    .i_tx_done(done_b), .o_grant_id(grant_b), .o_busy(busy_b), .o_timeout(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output of instance A at once.
  task automatic chk_a(input string tag, input logic [3:0] rdy, input logic st,
                       input logic [7:0] dat, input logic [1:0] gid,
                       input logic bsy, input logic tmo);
    chk({tag, ".ready"},   32'(ready_a), 32'(rdy));
    chk({tag, ".start"},   32'(start_a), 32'(st));
    chk({tag, ".data"},    32'(byte_a),  32'(dat));
    chk({tag, ".grant"},   32'(grant_a), 32'(gid));
    chk({tag, ".busy"},    32'(busy_a),  32'(bsy));
    chk({tag, ".timeout"}, 32'(tmo_a),   32'(tmo));
  endtask

  // From the cycle showing a start: one cycle into WAIT, done pulse, then the whole gap.
  task automatic run_frame_a();
    step(1);
    done_a = 1'b1;
    step(1);
    done_a = 1'b0;
    step(GAP_A);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    valid_a = 4'b0000;
    valid_b = 4'b0000;
    data_a  = {8'h13, 8'h12, 8'hA5, 8'h10};
    data_b  = {8'h00, 8'h5C, 8'h00, 8'h00};
    done_a  = 1'b0;
    done_b  = 1'b0;

    // Reset state
    step(2);
    chk_a("rst", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("rst_b.busy", 32'(busy_b), 32'h0);
    reset = 1'b0;
    step(1);
    chk_a("idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

    // 1) single requester 1, done 30 cycles after start
    valid_a = 4'b0010;
    step(1);
    chk_a("t1.grant", 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b0);
    valid_a = 4'b0000;
    step(1);
    chk_a("t1.wait", 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b1, 1'b0);
    step(28);
    chk("t1.busy_pre_done", 32'(busy_a), 32'h1);
    done_a = 1'b1;
    step(1);
    done_a = 1'b0;
    chk_a("t1.gap", 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b1, 1'b0);
    step(3);
    chk("t1.gap_last", 32'(busy_a), 32'h1);
    step(1);
    chk_a("t1.idle", 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0, 1'b0);

    // 2) requesters 0,2,3 held from reset: order 0,2,3,0
    reset   = 1'b1;
    valid_a = 4'b1101;
    step(1);
    chk_a("t2.rst", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    chk_a("t2.g0", 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    run_frame_a();
    chk("t2.no_early_grant", 32'(start_a), 32'h0);
    step(1);
    chk_a("t2.g2", 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1, 1'b0);
    run_frame_a();
    step(1);
    chk_a("t2.g3", 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0);
    run_frame_a();
    step(1);
    chk_a("t2.g0again", 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    valid_a = 4'b0000;
    run_frame_a();
    chk("t2.idle", 32'(busy_a), 32'h0);

    // 3) done held high after a frame must not complete the next one
    valid_a = 4'b0010;
    step(1);
    chk_a("t3.g1", 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b0);
    valid_a = 4'b0000;
    step(1);
    done_a = 1'b1;
    step(1 + GAP_A);
    chk("t3.idle1", 32'(busy_a), 32'h0);
    valid_a = 4'b0010;
    step(1);
    chk("t3.start2", 32'(start_a), 32'h1);
    valid_a = 4'b0000;
    step(10);
    chk("t3.sticky_busy", 32'(busy_a), 32'h1);
    done_a = 1'b0;
    step(1);
    done_a = 1'b1;
    step(1);
    done_a = 1'b0;
    step(GAP_A - 1);
    chk("t3.gap_last", 32'(busy_a), 32'h1);
    step(1);
    chk("t3.idle2", 32'(busy_a), 32'h0);

    // 4) watchdog: pulse 50 cycles after WAIT entry, grant held off until gap ends
    valid_a = 4'b0010;
    step(1);
    chk_a("t4.g1", 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b0);
    valid_a = 4'b0000;
    step(1);
    step(49);
    chk("t4.tmo_before", 32'(tmo_a), 32'h0);
    step(1);
    chk_a("t4.tmo", 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b1, 1'b1);
    valid_a = 4'b0001;
    step(1);
    chk("t4.tmo_pulse_end", 32'(tmo_a), 32'h0);
    step(2);
    chk("t4.gap_no_start", 32'(start_a), 32'h0);
    chk("t4.gap_busy", 32'(busy_a), 32'h1);
    step(1);
    chk("t4.idle_busy", 32'(busy_a), 32'h0);
    step(1);
    chk_a("t4.g0", 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    valid_a = 4'b0000;
    step(1);
    step(49);
    done_a = 1'b1;
    step(1);
    chk("t4.expiry_done.tmo", 32'(tmo_a), 32'h0);
    chk("t4.expiry_done.busy", 32'(busy_a), 32'h1);
    done_a = 1'b0;
    step(1);
    chk("t4.expiry_done.tmo2", 32'(tmo_a), 32'h0);
    step(2);
    chk("t4.gap2", 32'(busy_a), 32'h1);
    step(1);
    chk("t4.idle2", 32'(busy_a), 32'h0);

    // 5) reset in WAIT, then req0 beats pending req3
    valid_a = 4'b1000;
    step(1);
    chk_a("t5.g3", 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0);
    valid_a = 4'b0000;
    step(6);
    reset   = 1'b1;
    valid_a = 4'b1001;
    step(1);
    chk_a("t5.rst", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    chk_a("t5.g0", 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    valid_a = 4'b1000;
    run_frame_a();
    step(1);
    chk_a("t5.g3b", 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0);
    valid_a = 4'b0000;
    run_frame_a();

    // 6) no gap: back-to-back grants to requester 2
    valid_b = 4'b0100;
    step(1);
    chk("t6.start1", 32'(start_b), 32'h1);
    chk("t6.ready1", 32'(ready_b), 32'h4);
    chk("t6.data1", 32'(byte_b), 32'h5C);
    chk("t6.grant1", 32'(grant_b), 32'h2);
    step(1);
    done_b = 1'b1;
    step(1);
    done_b = 1'b0;
    chk("t6.idle1.start", 32'(start_b), 32'h0);
    chk("t6.idle1.busy", 32'(busy_b), 32'h0);
    step(1);
    chk("t6.start2", 32'(start_b), 32'h1);
    step(2);
    chk("t6.wait2.busy", 32'(busy_b), 32'h1);
    done_b = 1'b1;
    step(1);
    done_b = 1'b0;
    chk("t6.idle2.start", 32'(start_b), 32'h0);
    step(1);
    chk("t6.start3", 32'(start_b), 32'h1);
    chk("t6.tmo", 32'(tmo_b), 32'h0);
    valid_b = 4'b0000;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
